// File: rtl/challenge_responder_if.sv
// Bundle of the challenge, key and response handshake signals of the
// key-confirmation responder. The slave modport is the responder itself;
// the master modport is the side that drives challenges, keys and the
// downstream ready.
interface challenge_responder_if #(
  parameter int N_W   = 32,
  parameter int KEY_W = 4
);
  logic [N_W-1:0]   chal_i;
  logic             chal_valid_i;
  logic             chal_ready_o;
  logic [KEY_W-1:0] key_i;
  logic             key_valid_i;
  logic [KEY_W-1:0] resp_o;
  logic             resp_valid_o;
  logic             resp_ready_i;
  logic             resp_last_o;
  logic             done_o;
  logic             busy_o;
  logic             err_o;

  modport slave (
    input  chal_i, chal_valid_i, key_i, key_valid_i, resp_ready_i,
    output chal_ready_o, resp_o, resp_valid_o, resp_last_o, done_o, busy_o, err_o
  );

  modport master (
    output chal_i, chal_valid_i, key_i, key_valid_i, resp_ready_i,
    input  chal_ready_o, resp_o, resp_valid_o, resp_last_o, done_o, busy_o, err_o
  );
endinterface

// File: rtl/challenge_responder.sv
// Responder side of the post-DH key-confirmation handshake. Captures a
// challenge nonce, waits for the shared key, then streams the nonce back
// LSB chunk first, each KEY_W-bit chunk XORed with the key.
// Optional build macro RESP_TIMEOUT_EN: abort WAIT_KEY after TIMEOUT_CYC
// cycles without a key and raise the sticky err_o flag.
module challenge_responder #(
  parameter int N_W         = 32,
  parameter int KEY_W       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input logic clk,
  input logic rst,
  challenge_responder_if.slave bus
);
  localparam int BEATS = N_W / KEY_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, WAIT_KEY, SEND, DONE} state_t;

  state_t           state_reg, state_next;
  logic [N_W-1:0]   chal_reg, chal_next;
  logic [KEY_W-1:0] key_reg, key_next;
  logic [KEY_W-1:0] resp_reg, resp_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             valid_reg, valid_next;
  logic             last_reg, last_next;
`ifdef RESP_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_reg, tmo_next;
  logic             err_reg, err_next;
`endif

  // Nonce chunk n, counted from the least significant end.
  function automatic logic [KEY_W-1:0] chunk(input logic [N_W-1:0] c,
                                             input logic [CNT_W-1:0] n);
    return c[32'(n) * KEY_W +: KEY_W];
  endfunction

  assign cnt_inc = cnt_reg + CNT_W'(1);

  // State and datapath registers; async active-low reset aborts any transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      chal_reg  <= '0;
      key_reg   <= '0;
      resp_reg  <= '0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
`ifdef RESP_TIMEOUT_EN
      tmo_reg   <= '0;
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      chal_reg  <= chal_next;
      key_reg   <= key_next;
      resp_reg  <= resp_next;
      cnt_reg   <= cnt_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
`ifdef RESP_TIMEOUT_EN
      tmo_reg   <= tmo_next;
      err_reg   <= err_next;
`endif
    end
  end

  // Next-state logic; the next beat is precomputed so resp_o is always a register.
  always_comb begin
    state_next = state_reg;
    chal_next  = chal_reg;
    key_next   = key_reg;
    resp_next  = resp_reg;
    cnt_next   = cnt_reg;
    valid_next = valid_reg;
    last_next  = last_reg;
`ifdef RESP_TIMEOUT_EN
    tmo_next   = tmo_reg;
    err_next   = err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.chal_valid_i) begin
          chal_next  = bus.chal_i;
          cnt_next   = '0;
          state_next = WAIT_KEY;
`ifdef RESP_TIMEOUT_EN
          tmo_next   = '0;
          err_next   = 1'b0;
`endif
        end
      end
      WAIT_KEY: begin
        if (bus.key_valid_i) begin
          key_next   = bus.key_i;
          resp_next  = chal_reg[KEY_W-1:0] ^ bus.key_i;
          valid_next = 1'b1;
          last_next  = (BEATS == 1);
          state_next = SEND;
`ifdef RESP_TIMEOUT_EN
        end else if (tmo_reg == TMO_W'(TIMEOUT_CYC - 1)) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          tmo_next   = tmo_reg + TMO_W'(1);
`endif
        end
      end
      SEND: begin
        if (bus.resp_ready_i) begin
          if (last_reg) begin
            valid_next = 1'b0;
            last_next  = 1'b0;
            resp_next  = '0;
            state_next = DONE;
          end else begin
            cnt_next  = cnt_inc;
            resp_next = chunk(chal_reg, cnt_inc) ^ key_reg;
            last_next = (cnt_inc == LAST_IDX);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.chal_ready_o = (state_reg == IDLE);
  assign bus.busy_o       = (state_reg != IDLE);
  assign bus.done_o       = (state_reg == DONE);
  assign bus.resp_o       = resp_reg;
  assign bus.resp_valid_o = valid_reg;
  assign bus.resp_last_o  = last_reg;
`ifdef RESP_TIMEOUT_EN
  assign bus.err_o        = err_reg;
`else
  assign bus.err_o        = 1'b0;
`endif
endmodule

// File: tb/tb_challenge_responder.sv
// Directed bench for challenge_responder. A queue of expected beats, built
// from plain nonce/key arithmetic, is checked against the DUT every cycle;
// directed steps pin latency, ordering and reset/timeout behaviour.
module tb_challenge_responder;
  localparam int N_W   = 32;
  localparam int KEY_W = 4;
  localparam int BEATS = N_W / KEY_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic [KEY_W-1:0] exp_q[$];
  logic             exp_done = 1'b0;

  challenge_responder_if #(.N_W(N_W), .KEY_W(KEY_W)) bus ();

  challenge_responder #(.N_W(N_W), .KEY_W(KEY_W), .TIMEOUT_CYC(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Beat n of the response: nibble n of the nonce XOR key.
  function automatic logic [KEY_W-1:0] model_beat(input logic [N_W-1:0] c,
                                                  input logic [KEY_W-1:0] k, input int n);
    logic [N_W-1:0] sh;
    sh = c >> (KEY_W * n);
    return sh[KEY_W-1:0] ^ k;
  endfunction

  task automatic push_resp(input logic [N_W-1:0] c, input logic [KEY_W-1:0] k);
    for (int n = 0; n < BEATS; n++) exp_q.push_back(model_beat(c, k, n));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((bus.busy_o || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_finish_in_budget"}, 32'(n < budget), 1);
  endtask

  // Per-cycle comparison against the expected-beat queue.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      exp_done = 1'b0;
      check("rst_resp_valid", bus.resp_valid_o, 0);
      check("rst_resp", bus.resp_o, 0);
      check("rst_last", bus.resp_last_o, 0);
      check("rst_done", bus.done_o, 0);
      check("rst_busy", bus.busy_o, 0);
      check("rst_chal_ready", bus.chal_ready_o, 1);
      check("rst_err", bus.err_o, 0);
    end else begin
      check("done_pulse", bus.done_o, exp_done);
      exp_done = 1'b0;
      check("ready_vs_busy", bus.chal_ready_o, !bus.busy_o);
      if (bus.resp_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", bus.resp_valid_o, 0);
        end else begin
          check("beat", bus.resp_o, exp_q[0]);
          check("beat_last", bus.resp_last_o, 32'(exp_q.size() == 1));
          if (bus.resp_ready_i) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) exp_done = 1'b1;
          end
        end
      end else begin
        check("idle_resp", bus.resp_o, 0);
        check("idle_last", bus.resp_last_o, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [KEY_W-1:0] lit[BEATS];
    int n;
    lit = '{4'h2, 4'hD, 4'hC, 4'hF, 4'hE, 4'h9, 4'h8, 4'hB};
    bus.chal_i = '0; bus.chal_valid_i = 0; bus.key_i = '0; bus.key_valid_i = 0;
    bus.resp_ready_i = 0;

    // Pin the model against hand-computed beats.
    for (int i = 0; i < BEATS; i++) check("model_literal", model_beat(32'h12345678, 4'hA, i), lit[i]);

    repeat (3) tick();
    rst = 1;
    tick();

    // 1: basic response.
    bus.key_i = 4'hA; bus.key_valid_i = 1; bus.resp_ready_i = 1;
    bus.chal_i = 32'h12345678; bus.chal_valid_i = 1;
    push_resp(32'h12345678, 4'hA);
    tick();
    bus.chal_valid_i = 0;
    check("t1_wait_no_valid", bus.resp_valid_o, 0);
    check("t1_busy", bus.busy_o, 1);
    tick();
    check("t1_first_valid", bus.resp_valid_o, 1);
    check("t1_first_beat", bus.resp_o, 4'h2);
    n = 0;
    while (bus.busy_o && n < 30) begin tick(); n++; end
    check("t1_cycles_to_idle", n, 9);
    check("t1_err", bus.err_o, 0);
    $display("t1 basic response done at %0t", $time);

    // 2: backpressure with ready pattern 1,0,0,1,0,0...
    bus.chal_i = 32'h12345678; bus.chal_valid_i = 1;
    push_resp(32'h12345678, 4'hA);
    tick();
    bus.chal_valid_i = 0;
    n = 0;
    while ((bus.busy_o || exp_q.size() != 0) && n < 80) begin
      bus.resp_ready_i = (n % 3 == 0);
      tick();
      n++;
    end
    check("t2_finish_in_budget", 32'(n < 80), 1);
    bus.resp_ready_i = 1;
    $display("t2 backpressure done at %0t", $time);

    // 3: late key, then key change mid-SEND.
    bus.key_valid_i = 0; bus.key_i = 4'h0;
    bus.chal_i = 32'h12345678; bus.chal_valid_i = 1;
    push_resp(32'h12345678, 4'h3);
    tick();
    bus.chal_valid_i = 0;
    repeat (10) tick();
    check("t3_no_beat_without_key", bus.resp_valid_o, 0);
    check("t3_busy_waiting", bus.busy_o, 1);
    bus.key_i = 4'h3; bus.key_valid_i = 1;
    tick();
    check("t3_first_valid", bus.resp_valid_o, 1);
    check("t3_first_beat", bus.resp_o, 4'hB);
    tick();
    bus.key_i = 4'hF;
    wait_idle("t3", 40);
    $display("t3 late key done at %0t", $time);

    // 4: challenge offered while busy.
    bus.key_i = 4'hA;
    bus.chal_i = 32'h12345678; bus.chal_valid_i = 1;
    push_resp(32'h12345678, 4'hA);
    tick();
    bus.chal_valid_i = 0;
    repeat (2) tick();
    bus.chal_i = 32'hFFFFFFFF; bus.chal_valid_i = 1;
    #1;
    check("t4_ready_low_in_send", bus.chal_ready_o, 0);
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin tick(); n++; end
    check("t4_first_done_in_budget", 32'(n < 40), 1);
    push_resp(32'hFFFFFFFF, 4'hA);
    n = 0;
    while (!bus.chal_ready_o && n < 10) begin tick(); n++; end
    check("t4_back_to_idle", bus.chal_ready_o, 1);
    tick();
    bus.chal_valid_i = 0;
    wait_idle("t4", 40);
    $display("t4 challenge during busy done at %0t", $time);

    // 5: reset at beat 4.
    bus.chal_i = 32'h12345678; bus.chal_valid_i = 1;
    push_resp(32'h12345678, 4'hA);
    tick();
    bus.chal_valid_i = 0;
    tick();
    repeat (4) tick();
    check("t5_beat4", bus.resp_o, 4'hE);
    rst = 0;
    #1;
    check("t5_async_valid", bus.resp_valid_o, 0);
    check("t5_async_resp", bus.resp_o, 0);
    check("t5_async_busy", bus.busy_o, 0);
    check("t5_async_chal_ready", bus.chal_ready_o, 1);
    repeat (2) tick();
    rst = 1;
    tick();
    check("t5_no_done", bus.done_o, 0);
    bus.key_i = 4'h5;
    bus.chal_i = 32'hCAFEF00D; bus.chal_valid_i = 1;
    push_resp(32'hCAFEF00D, 4'h5);
    tick();
    bus.chal_valid_i = 0;
    wait_idle("t5", 40);
    $display("t5 reset mid-send done at %0t", $time);

    // 6: no key at all.
    bus.key_valid_i = 0;
    bus.chal_i = 32'h0BADBEEF; bus.chal_valid_i = 1;
    tick();
    bus.chal_valid_i = 0;
`ifdef RESP_TIMEOUT_EN
    n = 0;
    while (bus.busy_o && n < 40) begin tick(); n++; end
    check("t6_timeout_cycles", n, 16);
    check("t6_err_set", bus.err_o, 1);
    check("t6_idle", bus.chal_ready_o, 1);
    bus.key_i = 4'hA; bus.key_valid_i = 1;
    bus.chal_i = 32'h12345678; bus.chal_valid_i = 1;
    push_resp(32'h12345678, 4'hA);
    tick();
    bus.chal_valid_i = 0;
    check("t6_err_cleared", bus.err_o, 0);
    wait_idle("t6", 40);
`else
    repeat (40) tick();
    check("t6_still_busy", bus.busy_o, 1);
    check("t6_err_zero", bus.err_o, 0);
    bus.key_i = 4'hA; bus.key_valid_i = 1;
    push_resp(32'h0BADBEEF, 4'hA);
    wait_idle("t6", 40);
`endif
    $display("t6 missing key done at %0t", $time);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/challenge_responder.md
Name: challenge_responder

Overview:
Responder side of the key-confirmation handshake that follows the Diffie-Hellman exchange. It accepts a challenge nonce from the initiator and waits for the locally derived shared key. It then returns the response as a serial stream of key-width beats, each beat being one nonce chunk XORed with the key. Its output feeds the initiator-side confirmation checker, which XORs each beat with its own key and compares the result to its nonce.

Parameters:
N_W, 32, challenge nonce width in bits; must be an integer multiple of KEY_W.
KEY_W, 4, shared-key width; also the response beat width.
TIMEOUT_CYC, 255, maximum cycles spent in WAIT_KEY; used only with RESP_TIMEOUT_EN.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  reset, asynchronous, active-low.
chal_i  input  N_W  challenge nonce.
chal_valid_i  input  1  challenge valid.
chal_ready_o  output  1  challenge ready; high only in IDLE.
key_i  input  KEY_W  shared key from the DH core.
key_valid_i  input  1  level; high while key_i is valid.
resp_o  output  KEY_W  response beat.
resp_valid_o  output  1  response beat valid.
resp_ready_i  input  1  downstream ready.
resp_last_o  output  1  marks the final beat.
done_o  output  1  one-cycle pulse after the final beat is accepted.
busy_o  output  1  high in any state other than IDLE.
err_o  output  1  sticky timeout flag; tied to 0 without RESP_TIMEOUT_EN.

Behaviour:
- Reset (async, rst=0): state=IDLE; chal_q=0, key_q=0, beat counter=0.
- Output values at reset: chal_ready_o=1, resp_o=0, resp_valid_o=0, resp_last_o=0, done_o=0, busy_o=0, err_o=0.
- Reset mid-operation aborts the transfer immediately; no done_o pulse is generated.
- BEATS = N_W/KEY_W (8 at defaults). The beat counter is ceil(log2(BEATS)) bits wide.
- IDLE: chal_ready_o=1. On chal_valid_i&chal_ready_o:
  - capture chal_q=chal_i;
  - clear the beat counter;
  - clear err_o;
  - go to WAIT_KEY.
- WAIT_KEY: chal_ready_o=0; chal_valid_i is ignored. On key_valid_i=1:
  - capture key_q=key_i;
  - load resp_o = chal_q[KEY_W-1:0] ^ key_i;
  - assert resp_valid_o; assert resp_last_o if BEATS==1;
  - go to SEND.
- SEND: resp_valid_o=1, and resp_o holds beat n = chal_q[n*KEY_W +: KEY_W] ^ key_q (LSB chunk first).
  - resp_o and resp_valid_o are stable while resp_ready_i=0.
  - On resp_ready_i=1 with a non-last beat: increment the counter and register the next beat on the same edge. Back-to-back acceptance gives one beat per cycle.
  - resp_last_o=1 exactly while n==BEATS-1.
  - On acceptance of the last beat: drop resp_valid_o and resp_last_o, set resp_o=0, go to DONE.
  - key_valid_i and key_i changes during SEND are ignored; key_q is frozen.
- DONE: done_o=1 for one cycle, then go to IDLE.
- Latency, with key_valid_i already high: challenge handshake at edge E0; first beat valid after edge E1; last beat accepted at edge E_k; done_o high in the cycle after E_k.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.

Optional Feature:
RESP_TIMEOUT_EN:
- When defined: a counter runs in WAIT_KEY and is cleared on entry.
- If key_valid_i stays 0 for TIMEOUT_CYC consecutive cycles, set err_o=1 and go to IDLE without a response or done_o.
- err_o stays high until the next accepted challenge.
- When undefined: WAIT_KEY waits indefinitely, no counter is instantiated, and err_o is held at 0.

Test Plan:
1. Basic response: chal_i=0x12345678, key_valid_i=1, key_i=0xA, resp_ready_i=1 → beats 2,D,C,F,E,9,8,B on consecutive cycles; resp_last_o on B; done_o one cycle later; busy_o low after DONE.
2. Backpressure: same stimulus with resp_ready_i toggling 1,0,0,1,... → each beat held stable while ready=0; sequence unchanged; no beat dropped or duplicated.
3. Late key and key change: key_valid_i=0 for 10 cycles, then 0x3 → first beat 0x8^0x3=0xB appears one cycle after key_valid_i rises. Changing key_i to 0xF mid-SEND leaves all remaining beats computed with 0x3.
4. Challenge during busy: drive chal_valid_i with 0xFFFFFFFF while in SEND → chal_ready_o=0; original response completes unaltered; the new challenge is accepted once back in IDLE.
5. Reset mid-SEND: assert rst at beat 4 → all outputs return to reset values asynchronously; no done_o; a new challenge works normally after reset release.
6. Timeout (RESP_TIMEOUT_EN, TIMEOUT_CYC=16): no key_valid_i → err_o=1 after 16 WAIT_KEY cycles, state IDLE, no resp_valid_o. Next challenge clears err_o. Without the macro: busy_o stays 1 and err_o=0.
